// File: rtl/branch_unit_pkg.sv
// Shared constants for the branch unit: opcodes, funct3 codes and the FSM state encoding.
package branch_unit_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        StRun,
        StKill
    } state_e;

endpackage

// File: rtl/branch_unit_imm_gen.sv
// Combinational immediate decoder: sign-extended B, J and I immediates from an RV32I word.
module branch_imm_gen (
    input  logic [31:0] instr,
    output logic [31:0] imm_b,
    output logic [31:0] imm_j,
    output logic [31:0] imm_i
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch resolution with a registered one-cycle PC redirect and a kill shadow.
// Optional feature: define BRANCH_MISALIGN_CHECK_EN to trap taken targets with bit 1 set.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int unsigned SHADOW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        link_we,
    output logic [4:0]  link_addr,
    output logic [31:0] link_data,
    output logic        killed,
    output logic        misalign_trap
);

    localparam logic [2:0] SHADOW_CNT = 3'(SHADOW);

    logic [31:0] imm_b, imm_j, imm_i;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        is_jal, is_jalr, is_branch;
    logic        br_cond;
    logic        take;
    logic        misalign;
    logic [31:0] target;
    state_e      state_q;
    logic [2:0]  cnt_q;

    branch_imm_gen u_imm_gen (
        .instr (in_instr),
        .imm_b (imm_b),
        .imm_j (imm_j),
        .imm_i (imm_i)
    );

    assign opcode    = in_instr[6:0];
    assign funct3    = in_instr[14:12];
    assign rd        = in_instr[11:7];
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR) && (funct3 == F3_JALR);
    assign is_branch = (opcode == OP_BRANCH);

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            F3_BEQ:  br_cond = (rs1_data == rs2_data);
            F3_BNE:  br_cond = (rs1_data != rs2_data);
            F3_BLT:  br_cond = ($signed(rs1_data) < $signed(rs2_data));
            F3_BGE:  br_cond = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: br_cond = (rs1_data < rs2_data);
            F3_BGEU: br_cond = (rs1_data >= rs2_data);
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        if (is_jalr) begin
            target = (rs1_data + imm_i) & ~32'd1;
        end else if (is_jal) begin
            target = in_pc + imm_j;
        end else begin
            target = in_pc + imm_b;
        end
    end

    assign take = in_valid && (is_jal || is_jalr || (is_branch && br_cond));

`ifdef BRANCH_MISALIGN_CHECK_EN
    assign misalign = target[1];
`else
    assign misalign = 1'b0;
`endif

    // Pulse outputs default low each cycle; target and link fields hold until next update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StRun;
            cnt_q         <= 3'd0;
            branch_taken  <= 1'b0;
            branch_target <= 32'd0;
            link_we       <= 1'b0;
            link_addr     <= 5'd0;
            link_data     <= 32'd0;
            killed        <= 1'b0;
            misalign_trap <= 1'b0;
        end else begin
            branch_taken  <= 1'b0;
            link_we       <= 1'b0;
            killed        <= 1'b0;
            misalign_trap <= 1'b0;
            case (state_q)
                StRun: begin
                    if (take) begin
                        branch_target <= target;
                        if (misalign) begin
                            misalign_trap <= 1'b1;
                        end else begin
                            branch_taken <= 1'b1;
                            if ((is_jal || is_jalr) && (rd != 5'd0)) begin
                                link_we   <= 1'b1;
                                link_addr <= rd;
                                link_data <= in_pc + 32'd4;
                            end
                            if (SHADOW_CNT != 3'd0) begin
                                state_q <= StKill;
                                cnt_q   <= SHADOW_CNT;
                            end
                        end
                    end
                end
                StKill: begin
                    killed <= in_valid;
                    if (cnt_q <= 3'd1) begin
                        state_q <= StRun;
                        cnt_q   <= 3'd0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= StRun;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: directed vectors push expectations, a monitor pops and checks.
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = 32'd0;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        link_we;
    logic [4:0]  link_addr;
    logic [31:0] link_data;
    logic        killed;
    logic        misalign_trap;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic        taken;
        logic [31:0] target;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        kill;
        logic        trap;
        bit          full;
    } exp_t;

    exp_t sb[$];

    branch_unit #(.SHADOW(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_pc         (in_pc),
        .in_instr      (in_instr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .link_we       (link_we),
        .link_addr     (link_addr),
        .link_data     (link_data),
        .killed        (killed),
        .misalign_trap (misalign_trap)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rd,
                                          input logic [2:0] f3);
        return {imm[11:0], 5'd1, f3, rd, 7'b1100111};
    endfunction

    task automatic step(input string name, input logic v, input logic [31:0] pc,
                        input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic tk, input logic [31:0] tgt, input logic we,
                        input logic [4:0] ad, input logic [31:0] dt, input logic kl,
                        input logic tp, input bit full = 1'b0);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
        rs1_data = a;
        rs2_data = b;
        e = '{name, tk, tgt, we, ad, dt, kl, tp, full};
        sb.push_back(e);
    endtask

    task automatic idle(input string name);
        step(name, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 32'd0, 0, 5'd0, 32'd0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        bit   ok;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                ok = (branch_taken == e.taken) && (link_we == e.we) && (killed == e.kill) &&
                     (misalign_trap == e.trap);
                if (e.taken || e.trap || e.full) ok = ok && (branch_target == e.target);
                if (e.we || e.full) ok = ok && (link_addr == e.addr) && (link_data == e.data);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL %s: got tk=%b tgt=%h we=%b ad=%0d dt=%h kl=%b tp=%b, want tk=%b tgt=%h we=%b ad=%0d dt=%h kl=%b tp=%b",
                             e.name, branch_taken, branch_target, link_we, link_addr, link_data,
                             killed, misalign_trap, e.taken, e.target, e.we, e.addr, e.data,
                             e.kill, e.trap);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : driver
        step("reset0", 0, 0, 0, 0, 0, 0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 1'b1);
        step("reset1", 0, 0, 0, 0, 0, 0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{"reset_release", 0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 1'b1});

        step("beq_taken", 1, 32'h10, enc_b(32'd8, 3'b000), 32'd5, 32'd5,
             1, 32'h18, 0, 5'd0, 32'd0, 0, 0);
        step("kill1", 1, 32'h14, enc_b(32'd8, 3'b000), 32'd1, 32'd1,
             0, 32'd0, 0, 5'd0, 32'd0, 1, 0);
        step("kill2", 1, 32'h18, enc_b(32'd8, 3'b000), 32'd1, 32'd1,
             0, 32'd0, 0, 5'd0, 32'd0, 1, 0);
        step("bne_equal", 1, 32'h18, enc_b(32'd8, 3'b001), 32'd7, 32'd7,
             0, 32'd0, 0, 5'd0, 32'd0, 0, 0);
        step("jal_rd1", 1, 32'h20, enc_j(32'h100, 5'd1), 32'd0, 32'd0,
             1, 32'h120, 1, 5'd1, 32'h24, 0, 0);
        idle("shadow_idle_a");
        idle("shadow_idle_b");
        step("jal_rd0", 1, 32'h20, enc_j(32'h100, 5'd0), 32'd0, 32'd0,
             1, 32'h120, 0, 5'd0, 32'd0, 0, 0);
        idle("idle_c");
        idle("idle_d");
        step("blt_signed", 1, 32'h40, enc_b(32'h10, 3'b100), 32'hFFFF_FFFF, 32'd1,
             1, 32'h50, 0, 5'd0, 32'd0, 0, 0);
        idle("idle_e");
        idle("idle_f");
        step("bltu_nt", 1, 32'h40, enc_b(32'h10, 3'b110), 32'hFFFF_FFFF, 32'd1,
             0, 32'd0, 0, 5'd0, 32'd0, 0, 0);
        step("bge_neg_imm", 1, 32'h100, enc_b(32'hFFFF_FFF0, 3'b101), 32'd1, 32'hFFFF_FFFF,
             1, 32'hF0, 0, 5'd0, 32'd0, 0, 0);
        idle("idle_g");
        idle("idle_h");
        step("bgeu_nt", 1, 32'h100, enc_b(32'h8, 3'b111), 32'd1, 32'hFFFF_FFFF,
             0, 32'd0, 0, 5'd0, 32'd0, 0, 0);
        step("f3_010_nt", 1, 32'h100, enc_b(32'h8, 3'b010), 32'd0, 32'd0,
             0, 32'd0, 0, 5'd0, 32'd0, 0, 0);
        step("alu_nop", 1, 32'h104, 32'h00B5_0533, 32'd0, 32'd0,
             0, 32'd0, 0, 5'd0, 32'd0, 0, 0);
        step("jalr_f3_nop", 1, 32'h108, enc_i(32'd2, 5'd3, 3'b001), 32'h1000, 32'd0,
             0, 32'd0, 0, 5'd0, 32'd0, 0, 0);
        step("jal_wrap", 1, 32'hFFFF_FFFC, enc_j(32'd8, 5'd5), 32'd0, 32'd0,
             1, 32'h4, 1, 5'd5, 32'h0, 0, 0);
        idle("idle_i");
        idle("idle_j");
`ifdef BRANCH_MISALIGN_CHECK_EN
        step("jalr_misalign", 1, 32'h60, enc_i(32'd2, 5'd3, 3'b000), 32'h1001, 32'd0,
             0, 32'h1002, 0, 5'd0, 32'd0, 0, 1);
        step("after_trap", 1, 32'h80, enc_b(32'd4, 3'b101), 32'd1, 32'hFFFF_FFFF,
             1, 32'h84, 0, 5'd0, 32'd0, 0, 0);
`else
        step("jalr_misalign", 1, 32'h60, enc_i(32'd2, 5'd3, 3'b000), 32'h1001, 32'd0,
             1, 32'h1002, 1, 5'd3, 32'h64, 0, 0);
        step("after_jalr", 1, 32'h80, enc_b(32'd4, 3'b101), 32'd1, 32'hFFFF_FFFF,
             0, 32'd0, 0, 5'd0, 32'd0, 1, 0);
`endif
        idle("idle_k");
        idle("idle_l");
        idle("idle_m");
        step("pre_reset_beq", 1, 32'h10, enc_b(32'd8, 3'b000), 32'd0, 32'd0,
             1, 32'h18, 0, 5'd0, 32'd0, 0, 0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        sb.push_back('{"reset_mid_kill", 0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_pc    = 32'h200;
        in_instr = enc_b(32'h20, 3'b000);
        rs1_data = 32'd3;
        rs2_data = 32'd3;
        sb.push_back('{"post_reset_beq", 1, 32'h220, 0, 5'd0, 32'd0, 0, 0, 1'b0});
        step("post_reset_kill", 1, 32'h204, enc_b(32'h20, 3'b000), 32'd3, 32'd3,
             0, 32'd0, 0, 5'd0, 32'd0, 1, 0);
        idle("idle_n");
        idle("idle_o");
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
